// File: rtl/mcs4_ram_bank.sv
// One bank of MCS-4 style RAM chips (4002-like): main/status characters and output ports,
// driven by the CPU bus phases, plus a side-band debug port for main memory.
module mcs4_ram_bank #(
    parameter int BANK_SEL      = 0,
    parameter int NUM_CHIPS     = 4,
    parameter int REGS_PER_CHIP = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   sync,
    input  logic [3:0]             cm_ram,
    input  logic [3:0]             dbus_in,
    output logic [3:0]             dbus_out,
    output logic                   dbus_oe,
    output logic [4*NUM_CHIPS-1:0] io_out,
    input  logic                   dbg_req,
    input  logic                   dbg_we,
    input  logic [7:0]             dbg_addr,
    input  logic [3:0]             dbg_wdata,
    output logic                   dbg_ack,
    output logic [3:0]             dbg_rdata
);

    localparam logic [2:0] PH_M2    = 3'd4;
    localparam logic [2:0] PH_X1    = 3'd5;
    localparam logic [2:0] PH_X2    = 3'd6;
    localparam logic [2:0] PH_X3    = 3'd7;
    localparam logic [2:0] CHIP_LIM = 3'(NUM_CHIPS);
    localparam logic [2:0] REG_LIM  = 3'(REGS_PER_CHIP);
    localparam logic [3:0] BANK_MASK = 4'(1 << BANK_SEL);

    logic [2:0]             phase_q, phase_d;
    logic                   locked_q, locked_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic                   src_valid_q, src_valid_d;
    logic [7:0]             addr_q, addr_d;
    logic [3:0]             opa_q, opa_d;
    logic [3:0]             main_q   [4][4][16];
    logic [3:0]             main_d   [4][4][16];
    logic [3:0]             status_q [4][4][4];
    logic [3:0]             status_d [4][4][4];
    logic [4*NUM_CHIPS-1:0] io_q, io_d;
    logic [3:0]             dbus_out_q, dbus_out_d;
    logic                   dbus_oe_q, dbus_oe_d;
    logic                   dbg_ack_q, dbg_ack_d;
    logic [3:0]             dbg_rdata_q, dbg_rdata_d;

    logic       cm_sel;
    logic       cpu_sel;
    logic       cpu_hit;
    logic       cpu_is_read;
    logic [3:0] cpu_rdata;
    logic       dbg_sel;
    logic       dbg_svc;

    function automatic logic addr_in_range(input logic [7:0] a);
        return ({1'b0, a[7:6]} < CHIP_LIM) && ({1'b0, a[5:4]} < REG_LIM);
    endfunction

    assign cm_sel      = |(cm_ram & BANK_MASK);
    assign cpu_sel     = addr_in_range(addr_q);
    assign cpu_hit     = cmd_valid_q && cpu_sel;
    assign cpu_is_read = (opa_q == 4'h8) || (opa_q == 4'h9) || (opa_q == 4'hB) ||
                         (opa_q[3:2] == 2'b11);
    assign cpu_rdata   = (opa_q[3:2] == 2'b11) ? status_q[addr_q[7:6]][addr_q[5:4]][opa_q[1:0]]
                                               : main_q[addr_q[7:6]][addr_q[5:4]][addr_q[3:0]];
    assign dbg_sel     = addr_in_range(dbg_addr);

    // Debug handshake: dbg_req with its address/data is held until dbg_ack; the request is
    // serviced in the first cycle that is not X2 and dbg_ack (with dbg_rdata) follows for one cycle.
    assign dbg_svc     = dbg_req && !dbg_ack_q && (phase_q != PH_X2);

    always_comb begin
        phase_d     = sync ? 3'd0 : phase_q + 3'd1;
        locked_d    = locked_q | sync;
        cmd_valid_d = cmd_valid_q;
        src_valid_d = src_valid_q;
        addr_d      = addr_q;
        opa_d       = opa_q;
        main_d      = main_q;
        status_d    = status_q;
        io_d        = io_q;
        dbus_out_d  = 4'h0;
        dbus_oe_d   = 1'b0;
        dbg_ack_d   = dbg_svc;
        dbg_rdata_d = dbg_rdata_q;

        if (locked_q) begin
            case (phase_q)
                PH_M2: begin
                    cmd_valid_d = cm_sel;
                    opa_d       = dbus_in;
                end
                // Read data is captured at the end of X1 so the bus is driven for exactly X2.
                PH_X1: begin
                    if (cpu_hit && cpu_is_read) begin
                        dbus_oe_d  = 1'b1;
                        dbus_out_d = cpu_rdata;
                    end
                end
                PH_X2: begin
                    src_valid_d = cm_sel;
                    if (cm_sel) addr_d[7:4] = dbus_in;
                    if (cpu_hit) begin
                        case (opa_q)
                            4'h0: main_d[addr_q[7:6]][addr_q[5:4]][addr_q[3:0]] = dbus_in;
                            4'h1: begin
                                for (int k = 0; k < NUM_CHIPS; k++) begin
                                    if (addr_q[7:6] == 2'(k)) io_d[4*k +: 4] = dbus_in;
                                end
                            end
                            4'h4, 4'h5, 4'h6, 4'h7:
                                status_d[addr_q[7:6]][addr_q[5:4]][opa_q[1:0]] = dbus_in;
                            default: ;
                        endcase
                    end
                end
                PH_X3: begin
                    if (src_valid_q) addr_d[3:0] = dbus_in;
                end
                default: ;
            endcase
        end

        if (dbg_svc) begin
            if (dbg_we) begin
                if (dbg_sel) main_d[dbg_addr[7:6]][dbg_addr[5:4]][dbg_addr[3:0]] = dbg_wdata;
            end else begin
                dbg_rdata_d = dbg_sel ? main_q[dbg_addr[7:6]][dbg_addr[5:4]][dbg_addr[3:0]] : 4'h0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q     <= 3'd0;
            locked_q    <= 1'b0;
            cmd_valid_q <= 1'b0;
            src_valid_q <= 1'b0;
            addr_q      <= 8'h00;
            opa_q       <= 4'h0;
            io_q        <= '0;
            dbus_out_q  <= 4'h0;
            dbus_oe_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
            dbg_rdata_q <= 4'h0;
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    for (int i = 0; i < 16; i++) main_q[c][r][i] <= 4'h0;
                    for (int s = 0; s < 4; s++) status_q[c][r][s] <= 4'h0;
                end
            end
        end else begin
            phase_q     <= phase_d;
            locked_q    <= locked_d;
            cmd_valid_q <= cmd_valid_d;
            src_valid_q <= src_valid_d;
            addr_q      <= addr_d;
            opa_q       <= opa_d;
            io_q        <= io_d;
            dbus_out_q  <= dbus_out_d;
            dbus_oe_q   <= dbus_oe_d;
            dbg_ack_q   <= dbg_ack_d;
            dbg_rdata_q <= dbg_rdata_d;
            main_q      <= main_d;
            status_q    <= status_d;
        end
    end

    assign dbus_out  = dbus_out_q;
    assign dbus_oe   = dbus_oe_q;
    assign io_out    = io_q;
    assign dbg_ack   = dbg_ack_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_mcs4_ram_bank.sv
// Randomized bench for mcs4_ram_bank: drives whole 8-phase instruction cycles and debug
// accesses, and compares against an instruction-level model of the RAM bank.
module tb_mcs4_ram_bank;

    localparam int         BS = 0;
    localparam int         NC = 2;
    localparam int         NR = 3;
    localparam logic [3:0] BM = 4'(1 << BS);

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sync = 1'b0;
    logic [3:0]      cm_ram = 4'h0;
    logic [3:0]      dbus_in = 4'h0;
    logic [3:0]      dbus_out;
    logic            dbus_oe;
    logic [4*NC-1:0] io_out;
    logic            dbg_req = 1'b0;
    logic            dbg_we = 1'b0;
    logic [7:0]      dbg_addr = 8'h00;
    logic [3:0]      dbg_wdata = 4'h0;
    logic            dbg_ack;
    logic [3:0]      dbg_rdata;

    // ---------------- clock / reset
    always #5 clk = ~clk;

    mcs4_ram_bank #(.BANK_SEL(BS), .NUM_CHIPS(NC), .REGS_PER_CHIP(NR)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sync      (sync),
        .cm_ram    (cm_ram),
        .dbus_in   (dbus_in),
        .dbus_out  (dbus_out),
        .dbus_oe   (dbus_oe),
        .io_out    (io_out),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_ack   (dbg_ack),
        .dbg_rdata (dbg_rdata)
    );

    // ---------------- scoreboard and model state
    int              n_checks = 0;
    int              n_pass = 0;
    logic [3:0]      exp_q[$];
    logic [3:0]      m_main   [4][4][16];
    logic [3:0]      m_status [4][4][4];
    logic [4*NC-1:0] m_io;
    logic [7:0]      m_addr;
    logic [3:0]      m_opa;
    bit              m_cmd, m_src, m_locked;
    int              tb_phase;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic bit in_rng(input logic [7:0] a);
        return (int'(a[7:6]) < NC) && (int'(a[5:4]) < NR);
    endfunction

    function automatic bit is_rd(input logic [3:0] op);
        return (op == 4'h8) || (op == 4'h9) || (op == 4'hB) || (op >= 4'hC);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                for (int i = 0; i < 16; i++) m_main[c][r][i] = 4'h0;
                for (int s = 0; s < 4; s++) m_status[c][r][s] = 4'h0;
            end
        m_io = '0; m_addr = 8'h00; m_opa = 4'h0;
        m_cmd = 0; m_src = 0; m_locked = 0;
        exp_q.delete();
    endtask

    // ---------------- driver tasks
    task automatic tick();
        @(posedge clk);
        tb_phase = sync ? 0 : (tb_phase + 1) % 8;
        #1;
    endtask

    task automatic idle();
        sync = 1'b0; cm_ram = 4'h0; dbus_in = 4'($urandom_range(0, 15));
        tick();
        check("idle_oe", dbus_oe, 1'b0);
    endtask

    task automatic do_sync();
        sync = 1'b1; cm_ram = 4'h0; dbus_in = 4'h0;
        tick();
        sync = 1'b0;
        m_locked = 1;
    endtask

    // One full instruction cycle: cm_m2/opa in M2, cm_x2/d_x2 in X2, d_x3 in X3.
    task automatic instr(input logic [3:0] cm_m2, input logic [3:0] opa, input logic [3:0] cm_x2,
                         input logic [3:0] d_x2, input logic [3:0] d_x3, input bit with_sync);
        bit         hit, rd;
        logic [3:0] rv;
        logic [1:0] c, r;
        while (tb_phase != 0) idle();
        if (m_locked) begin
            m_cmd = cm_m2[BS];
            m_opa = opa;
        end
        c   = m_addr[7:6];
        r   = m_addr[5:4];
        hit = m_cmd && in_rng(m_addr);
        rd  = hit && is_rd(m_opa);
        rv  = (m_opa >= 4'hC) ? m_status[c][r][m_opa[1:0]] : m_main[c][r][m_addr[3:0]];
        for (int p = 0; p < 8; p++) begin
            sync    = with_sync && (p == 7);
            cm_ram  = (p == 4) ? cm_m2 : (p == 6) ? cm_x2 : 4'h0;
            dbus_in = (p == 4) ? opa : (p == 6) ? d_x2 : (p == 7) ? d_x3 : 4'($urandom_range(0, 15));
            tick();
            check("bus_oe", dbus_oe, (p == 5) && rd);
            check("bus_out", dbus_out, ((p == 5) && rd) ? rv : 4'h0);
        end
        sync = 1'b0;
        if (hit) begin
            case (m_opa)
                4'h0: m_main[c][r][m_addr[3:0]] = d_x2;
                4'h1: m_io[4*c +: 4] = d_x2;
                4'h4, 4'h5, 4'h6, 4'h7: m_status[c][r][m_opa[1:0]] = d_x2;
                default: ;
            endcase
        end
        if (m_locked) begin
            m_src = cm_x2[BS];
            if (m_src) m_addr = {d_x2, d_x3};
        end
        if (with_sync) m_locked = 1;
        check("io_out", io_out, m_io);
    endtask

    task automatic src(input logic [7:0] a);
        instr(4'h0, 4'($urandom_range(0, 15)), BM, a[7:4], a[3:0], 1'b1);
    endtask

    task automatic cmd(input logic [3:0] op, input logic [3:0] d);
        instr(BM, op, 4'h0, d, 4'($urandom_range(0, 15)), 1'b1);
    endtask

    task automatic dbg_op(input bit we, input logic [7:0] a, input logic [3:0] wd);
        int exp_lat, lat;
        exp_lat = (tb_phase == 6) ? 2 : 1;
        if (we) begin
            if (in_rng(a)) m_main[a[7:6]][a[5:4]][a[3:0]] = wd;
        end else begin
            exp_q.push_back(in_rng(a) ? m_main[a[7:6]][a[5:4]][a[3:0]] : 4'h0);
        end
        sync = 1'b0; cm_ram = 4'h0;
        dbg_req = 1'b1; dbg_we = we; dbg_addr = a; dbg_wdata = wd;
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!dbg_ack && lat < 10);
        check("dbg_latency", lat, exp_lat);
        if (!we) check("dbg_rdata", dbg_rdata, exp_q.pop_front());
        dbg_req = 1'b0;
        tick();
        check("dbg_ack_pulse", dbg_ack, 1'b0);
    endtask

    task automatic dbg_at(input int ph, input bit we, input logic [7:0] a, input logic [3:0] wd);
        while (tb_phase != ph) idle();
        dbg_op(we, a, wd);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_oe"}, dbus_oe, 1'b0);
        check({tag, "_out"}, dbus_out, 4'h0);
        check({tag, "_io"}, io_out, '0);
        check({tag, "_ack"}, dbg_ack, 1'b0);
        check({tag, "_rdata"}, dbg_rdata, 4'h0);
    endtask

    // Drive an RDM up to X1, then reset in the middle of X1.
    task automatic reset_mid_x1();
        while (tb_phase != 0) idle();
        for (int p = 0; p < 5; p++) begin
            sync    = 1'b0;
            cm_ram  = (p == 4) ? BM : 4'h0;
            dbus_in = (p == 4) ? 4'h9 : 4'($urandom_range(0, 15));
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midrst");
        @(posedge clk);
        #1;
        check_outputs_zero("midrst_hold");
        rst_n = 1'b1;
        tb_phase = 0;
        model_reset();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- stimulus
    initial begin
        logic [7:0] a;
        logic [3:0] cmv;
        model_reset();
        tb_phase = 0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Nothing is latched before the first sync.
        instr(4'h0, 4'h0, BM, 4'h2, 4'h5, 1'b0);
        instr(BM, 4'h0, 4'h0, 4'h9, 4'h0, 1'b0);
        instr(BM, 4'h9, 4'h0, 4'h0, 4'h0, 1'b0);
        do_sync();
        dbg_op(1'b0, 8'h25, 4'h0);

        // Write, read back on the bus and via debug.
        src(8'h25);
        cmd(4'h0, 4'h9);
        cmd(4'h9, 4'h0);
        check("rdm_mem", m_main[0][2][5], 4'h9);
        dbg_op(1'b0, 8'h25, 4'h0);

        // Out-of-range chip: no write, no bus drive.
        src(8'hC5);
        cmd(4'h0, 4'hF);
        cmd(4'h9, 4'h0);
        dbg_op(1'b0, 8'hC5, 4'h0);
        src(8'h35);
        cmd(4'h0, 4'hE);
        dbg_op(1'b0, 8'h35, 4'h0);

        // Output ports and status characters.
        src(8'h00);
        cmd(4'h1, 4'h5);
        src(8'h40);
        cmd(4'h1, 4'hA);
        check("wmp_hi", io_out[7:4], 4'hA);
        check("wmp_lo", io_out[3:0], 4'h5);
        cmd(4'h6, 4'h7);
        cmd(4'hE, 4'h0);
        cmd(4'hC, 4'h0);
        cmd(4'h2, 4'h3);
        cmd(4'hA, 4'h0);

        // Other bank lines are ignored.
        instr(4'h0, 4'h0, 4'h2, 4'h1, 4'h1, 1'b1);
        instr(4'h2, 4'h0, 4'h0, 4'hB, 4'h0, 1'b1);
        instr(4'h2, 4'h9, 4'h0, 4'h0, 4'h0, 1'b1);
        cmd(4'h9, 4'h0);

        // Debug service deferred past X2; out-of-range debug accesses.
        dbg_at(6, 1'b1, 8'h47, 4'h3);
        dbg_at(5, 1'b0, 8'h47, 4'h0);
        dbg_at(6, 1'b0, 8'h47, 4'h0);
        dbg_at(2, 1'b1, 8'h87, 4'h6);
        dbg_at(3, 1'b0, 8'h87, 4'h0);
        dbg_at(4, 1'b1, 8'h32, 4'h6);
        dbg_at(1, 1'b0, 8'h32, 4'h0);

        // Randomized instruction and debug mix.
        for (int i = 0; i < 80; i++) begin
            cmv = ($urandom_range(0, 3) != 0) ? BM : 4'($urandom_range(0, 15));
            a   = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 9))
                0, 1, 2: instr(4'h0, 4'($urandom_range(0, 15)), cmv, a[7:4], a[3:0], 1'b1);
                3, 4, 5, 6, 7: instr(cmv, 4'($urandom_range(0, 15)), 4'h0,
                                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1);
                8: dbg_at($urandom_range(0, 7), 1'b0, a, 4'h0);
                default: dbg_at($urandom_range(0, 7), 1'b1, a, 4'($urandom_range(0, 15)));
            endcase
        end
        for (int i = 0; i < 12; i++) begin
            a = {2'($urandom_range(0, NC - 1)), 2'($urandom_range(0, NR - 1)), 4'($urandom_range(0, 15))};
            dbg_op(1'b0, a, 4'h0);
        end

        // Reset in the middle of an RDM clears everything; commands need a new sync.
        src(8'h25);
        cmd(4'h0, 4'h9);
        src(8'h40);
        cmd(4'h1, 4'hA);
        src(8'h25);
        dbg_op(1'b0, 8'h25, 4'h0);
        reset_mid_x1();
        tick();
        check("post_rst_oe", dbus_oe, 1'b0);
        instr(BM, 4'h0, 4'h0, 4'h7, 4'h0, 1'b0);
        do_sync();
        dbg_op(1'b0, 8'h25, 4'h0);
        dbg_op(1'b0, 8'h47, 4'h0);
        check("post_rst_io", io_out, '0);
        src(8'h13);
        cmd(4'h0, 4'hD);
        cmd(4'hB, 4'h0);
        dbg_op(1'b0, 8'h13, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
